// File: rtl/note_spawner_if.sv
// rtl/note_spawner_if.sv - chart-entry handshake plus note-slot bus bundle for note_spawner
//
// Signals:
//   entry_valid  chart FIFO has a note word
//   entry_data   note word, held while entry_valid=1 and entry_ready=0
//   entry_ready  one-cycle consume pulse from the spawner
//   m_addr       slot address (width bits)
//   m_read       slot read strobe
//   m_write      slot write strobe
//   m_be         byte enables
//   m_wdata      slot write data
//   m_rdata      slot read data, combinational in the m_read cycle
// Modports:
//   master  the spawner side (drives entry_ready and m_*)
//   slave   the FIFO / slot bank side
interface note_spawner_if #(
    parameter int width = 2
);
    logic             entry_valid;
    logic [31:0]      entry_data;
    logic             entry_ready;
    logic [width-1:0] m_addr;
    logic             m_read;
    logic             m_write;
    logic [3:0]       m_be;
    logic [31:0]      m_wdata;
    logic [31:0]      m_rdata;

    modport master (
        input  entry_valid, entry_data, m_rdata,
        output entry_ready, m_addr, m_read, m_write, m_be, m_wdata
    );

    modport slave (
        output entry_valid, entry_data, m_rdata,
        input  entry_ready, m_addr, m_read, m_write, m_be, m_wdata
    );
endinterface

// File: rtl/note_spawner.sv
// rtl/note_spawner.sv - bus initiator that places chart notes into free note slots
//
// Ports:
//   clk            system clock, rising edge
//   Reset          synchronous active-low reset
//   run            allows new chart entries to be accepted (checked in IDLE only)
//   clear_req      one-cycle pulse requesting all slots be zeroed
//   bus            note_spawner_if.master: chart handshake and slot bus
//   busy           FSM not in IDLE
//   full           in STALL (every slot occupied on the last scan)
//   spawned_count  notes written since reset, wraps at 16 bits
module note_spawner #(
    parameter int count        = 3,
    parameter int width        = 2,
    parameter int STALL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 run,
    input  logic                 clear_req,
    note_spawner_if.master       bus,
    output logic                 busy,
    output logic                 full,
    output logic [15:0]          spawned_count
);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [width-1:0]   LAST       = width'(count - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_STALL,
        S_CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   ptr_q, ptr_d;
    logic [width-1:0]   idx_q, idx_d;
    logic [width-1:0]   scanned_q, scanned_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               clear_pending_q, clear_pending_d;
    logic [15:0]        spawned_q, spawned_d;

    // Only the occupied flag of a slot word matters to the scan.
    logic unused_rdata;
    assign unused_rdata = ^bus.m_rdata[30:0];

    // Slot indices advance modulo count, which need not be a power of two.
    function automatic logic [width-1:0] wrap_inc(input logic [width-1:0] v);
        return (v == LAST) ? '0 : v + width'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            idx_q           <= '0;
            scanned_q       <= '0;
            stall_q         <= '0;
            clear_pending_q <= 1'b0;
            spawned_q       <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            idx_q           <= idx_d;
            scanned_q       <= scanned_d;
            stall_q         <= stall_d;
            clear_pending_q <= clear_pending_d;
            spawned_q       <= spawned_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        scanned_d = scanned_q;
        stall_d   = stall_q;
        spawned_d = spawned_q;
        // A clear request is remembered in any state until CLEAR starts.
        clear_pending_d = clear_pending_q | clear_req;
        case (state_q)
            S_IDLE: begin
                if (clear_pending_q || clear_req) begin
                    state_d         = S_CLEAR;
                    idx_d           = '0;
                    clear_pending_d = 1'b0;
                end else if (run && bus.entry_valid) begin
                    state_d   = S_SCAN;
                    idx_d     = ptr_q;
                    scanned_d = '0;
                end
            end
            S_SCAN: begin
                if (!bus.m_rdata[31]) begin
                    state_d = S_WRITE;
                end else if (scanned_q == LAST) begin
                    state_d = S_STALL;
                    stall_d = '0;
                end else begin
                    idx_d     = wrap_inc(idx_q);
                    scanned_d = wrap_inc(scanned_q);
                end
            end
            S_WRITE: begin
                ptr_d     = wrap_inc(idx_q);
                spawned_d = spawned_q + 16'd1;
                state_d   = S_IDLE;
            end
            S_STALL: begin
                if (stall_q == STALL_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            S_CLEAR: begin
                if (idx_q == LAST) begin
                    ptr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = wrap_inc(idx_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs decode the registered state only.
    always_comb begin
        bus.entry_ready = 1'b0;
        bus.m_addr      = '0;
        bus.m_read      = 1'b0;
        bus.m_write     = 1'b0;
        bus.m_be        = 4'h0;
        bus.m_wdata     = 32'h0;
        full            = 1'b0;
        busy            = (state_q != S_IDLE);
        case (state_q)
            S_SCAN: begin
                bus.m_read = 1'b1;
                bus.m_addr = idx_q;
                bus.m_be   = 4'hF;
            end
            S_WRITE: begin
                bus.m_write     = 1'b1;
                bus.m_addr      = idx_q;
                bus.m_be        = 4'hF;
                bus.m_wdata     = bus.entry_data | 32'h8000_0000;
                bus.entry_ready = 1'b1;
            end
            S_CLEAR: begin
                bus.m_write = 1'b1;
                bus.m_addr  = idx_q;
                bus.m_be    = 4'hF;
            end
            S_STALL: full = 1'b1;
            default: ;
        endcase
    end

    assign spawned_count = spawned_q;
endmodule
